core_mem_port_mux: RTL

- Parametrised successor to the core's two-requester memory mux; sits between NUM_REQ core-side memory clients (icache, load/store units, future dcache/prefetcher) and the single core memory port.
- Arbitrates requests in a runtime-selectable mode (fixed priority or round-robin) into a registered output with backpressure.
- Routes memory responses to per-requester response FIFOs using the top bits of access_id.
- Replaces the hardwired access_id[6] split and the 2-way fixed grant.

---
 rtl/core_mem_port_mux.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/core_mem_port_mux.sv
// core_mem_port_mux: NUM_REQ-way arbiter (fixed or round-robin) onto one registered memory
// request port, plus access_id-routed per-requester response FIFOs.

module core_mem_port_mux_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         vld,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic          do_pop;

  assign vld    = (cnt_q != '0);
  assign full   = (cnt_q == CW'(DEPTH));
  assign dout   = mem_q[rd_ptr_q];
  assign do_pop = pop && vld;

  // push is only ever raised by the parent when !full
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push)   wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end
endmodule

module core_mem_port_mux #(
  parameter int NUM_REQ        = 2,
  parameter int REQ_W          = 64,
  parameter int ID_W           = 7,
  parameter int RSP_FIFO_DEPTH = 4,
  parameter int SEL_W          = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     prio_mode,
  input  logic [NUM_REQ-1:0]       req_vld,
  input  logic [NUM_REQ*REQ_W-1:0] req_data,
  input  logic [NUM_REQ*ID_W-1:0]  req_id,
  output logic [NUM_REQ-1:0]       req_grant,
  output logic                     mem_req_vld,
  output logic [REQ_W-1:0]         mem_req_data,
  output logic [ID_W-1:0]          mem_req_id,
  input  logic                     mem_req_rdy,
  input  logic                     mem_rsp_vld,
  input  logic [REQ_W-1:0]         mem_rsp_data,
  input  logic [ID_W-1:0]          mem_rsp_id,
  output logic                     mem_rsp_rdy,
  output logic [NUM_REQ-1:0]       rsp_vld,
  output logic [NUM_REQ*REQ_W-1:0] rsp_data,
  output logic [NUM_REQ*ID_W-1:0]  rsp_id,
  input  logic [NUM_REQ-1:0]       rsp_rdy,
  output logic                     rsp_err
);
  localparam int IDXW = SEL_W + 1;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [REQ_W-1:0] data;
  } pkt_t;

  pkt_t             out_q, out_d;
  logic             out_vld_q, out_vld_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             rsp_err_q, rsp_err_d;

  logic             slot_free, gnt_found, gnt_fire;
  logic [SEL_W-1:0] gnt_idx, start;
  logic [IDXW-1:0]  cand;

  assign slot_free = !out_vld_q || mem_req_rdy;
  assign gnt_fire  = slot_free && gnt_found;

  // Rotating search; start is 0 in fixed mode so the lowest index wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    start     = prio_mode ? rr_ptr_q : '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, start} + IDXW'(k);
      if (cand >= IDXW'(NUM_REQ)) cand = cand - IDXW'(NUM_REQ);
      if (!gnt_found && req_vld[cand[SEL_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[SEL_W-1:0];
      end
    end
  end

  always_comb begin
    req_grant = '0;
    if (gnt_fire) req_grant[gnt_idx] = 1'b1;
  end

  always_comb begin
    out_d     = out_q;
    out_vld_d = out_vld_q;
    rr_ptr_d  = rr_ptr_q;
    if (gnt_fire) begin
      out_vld_d  = 1'b1;
      out_d.data = req_data[int'(gnt_idx)*REQ_W +: REQ_W];
      out_d.id   = req_id[int'(gnt_idx)*ID_W +: ID_W];
      if (prio_mode)
        rr_ptr_d = ({1'b0, gnt_idx} == IDXW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end else if (mem_req_rdy) begin
      out_vld_d = 1'b0;
    end
  end

  assign mem_req_vld  = out_vld_q;
  assign mem_req_data = out_q.data;
  assign mem_req_id   = out_q.id;

  // Response routing: top SEL_W bits of the id select the requester FIFO.
  logic [SEL_W-1:0]   dest;
  logic               dest_ok;
  logic [NUM_REQ-1:0] fifo_full, fifo_push;

  assign dest        = mem_rsp_id[ID_W-1 -: SEL_W];
  assign dest_ok     = ({1'b0, dest} < IDXW'(NUM_REQ));
  assign mem_rsp_rdy = dest_ok ? !fifo_full[dest] : 1'b1;
  assign rsp_err_d   = mem_rsp_vld && !dest_ok;
  assign rsp_err     = rsp_err_q;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    logic [ID_W+REQ_W-1:0] head;

    assign fifo_push[i] = mem_rsp_vld && dest_ok && (dest == SEL_W'(i)) && !fifo_full[i];

    core_mem_port_mux_rsp_fifo #(
      .DEPTH (RSP_FIFO_DEPTH),
      .W     (ID_W + REQ_W)
    ) u_fifo (
      .clk   (clk),
      .rst_n (reset),
      .push  (fifo_push[i]),
      .din   ({mem_rsp_id, mem_rsp_data}),
      .pop   (rsp_rdy[i]),
      .dout  (head),
      .vld   (rsp_vld[i]),
      .full  (fifo_full[i])
    );

    assign rsp_data[i*REQ_W +: REQ_W] = head[REQ_W-1:0];
    assign rsp_id[i*ID_W +: ID_W]     = head[ID_W+REQ_W-1:REQ_W];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q     <= '0;
      out_vld_q <= 1'b0;
      rr_ptr_q  <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
      rr_ptr_q  <= rr_ptr_d;
      rsp_err_q <= rsp_err_d;
    end
  end
endmodule
